// File: rtl/data_sram_resp.sv
// Data-SRAM responder for the execute stage: word-organised memory with byte-lane writes,
// registered read data and optional wait-state stretching with a stall request.
module data_sram_resp #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        rdata_valid,
    output logic        stallreq
);

    typedef enum logic {IDLE, WAIT} state_t;

    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_INIT  = 4'(WAIT_CYCLES - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [3:0]          wen_q, wen_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;

    logic [31:0]         mem [0:(1<<ADDR_W)-1];

    logic [ADDR_W-1:0]   in_idx;
    logic                commit, stall, mem_we;
    logic [ADDR_W-1:0]   c_idx;
    logic [3:0]          c_wen;
    logic [31:0]         c_wdata;
    logic                unused_addr;

    // Byte offset and high address bits alias onto the same word.
    assign in_idx      = data_sram_addr[ADDR_W+1:2];
    assign unused_addr = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wen_d    = wen_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        commit   = 1'b0;
        stall    = 1'b0;
        c_idx    = in_idx;
        c_wen    = data_sram_wen;
        c_wdata  = data_sram_wdata;
        case (state_q)
            IDLE: begin
                if (data_sram_en) begin
                    if (ZERO_WAIT) begin
                        commit = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        idx_d   = in_idx;
                        wen_d   = data_sram_wen;
                        wdata_d = data_sram_wdata;
                        cnt_d   = CNT_INIT;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Last stretched cycle: the en still present here is the same request.
                    commit  = 1'b1;
                    c_idx   = idx_q;
                    c_wen   = wen_q;
                    c_wdata = wdata_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (commit && (c_wen == 4'b0000)) begin
            rdata_d  = mem[c_idx];
            rvalid_d = 1'b1;
        end
    end

    assign mem_we          = commit && !rst && (c_wen != 4'b0000);
    assign stallreq        = stall && !rst;
    assign data_sram_rdata = rdata_q;
    assign rdata_valid     = rvalid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            wen_q    <= 4'b0000;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Array is never reset; only enabled lanes are touched.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (c_wen[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_sram_resp.sv
// Bench for data_sram_resp: a zero-wait and a three-wait instance checked against
// a word-array reference model with directed and random accesses.
module tb_data_sram_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, en0, rv0, st0;
    logic [3:0]  wen0;
    logic [31:0] addr0, wdata0, rdata0;
    logic        rst3, en3, rv3, st3;
    logic [3:0]  wen3;
    logic [31:0] addr3, wdata3, rdata3;

    data_sram_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst(rst0), .data_sram_en(en0), .data_sram_wen(wen0),
        .data_sram_addr(addr0), .data_sram_wdata(wdata0),
        .data_sram_rdata(rdata0), .rdata_valid(rv0), .stallreq(st0));

    data_sram_resp #(.ADDR_W(10), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .rst(rst3), .data_sram_en(en3), .data_sram_wen(wen3),
        .data_sram_addr(addr3), .data_sram_wdata(wdata3),
        .data_sram_rdata(rdata3), .rdata_valid(rv3), .stallreq(st3));

    int total = 0;
    int bad   = 0;
    logic [31:0] m0 [0:1023];
    logic [31:0] m3 [0:1023];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(a[11:2]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en0 = e; wen0 = w; addr0 = a; wdata0 = d;
    endtask

    task automatic drv3(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en3 = e; wen3 = w; addr3 = a; wdata3 = d;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst3 = 1'b1;
        drv0(1'b0, 4'h0, 32'h0, 32'h0);
        drv3(1'b1, 4'hF, 32'h20, 32'h5);
        tick();
        total++; if (rdata0 !== 32'd0) begin bad++; $display("FAIL reset_rdata0 got=%h exp=0", rdata0); end
        total++; if (rv0 !== 1'b0) begin bad++; $display("FAIL reset_valid0 got=%b exp=0", rv0); end
        total++; if (st0 !== 1'b0) begin bad++; $display("FAIL reset_stall0 got=%b exp=0", st0); end
        total++; if (rdata3 !== 32'd0) begin bad++; $display("FAIL reset_rdata3 got=%h exp=0", rdata3); end
        total++; if (rv3 !== 1'b0) begin bad++; $display("FAIL reset_valid3 got=%b exp=0", rv3); end
        total++; if (st3 !== 1'b0) begin bad++; $display("FAIL reset_stall3 got=%b exp=0", st3); end
        drv3(1'b0, 4'h0, 32'h0, 32'h0);
        rst0 = 1'b0; rst3 = 1'b0;
        tick();
    endtask

    task automatic test_w0_basic();
        drv0(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        #1;
        total++; if (st0 !== 1'b0) begin bad++; $display("FAIL w0_wr_stall got=%b exp=0", st0); end
        tick();
        m0[4] = 32'hDEADBEEF;
        total++; if (rv0 !== 1'b0) begin bad++; $display("FAIL w0_wr_valid got=%b exp=0", rv0); end
        drv0(1'b1, 4'h0, 32'h10, 32'h0);
        #1;
        total++; if (st0 !== 1'b0) begin bad++; $display("FAIL w0_rd_stall got=%b exp=0", st0); end
        tick();
        total++; if (rdata0 !== 32'hDEADBEEF) begin bad++; $display("FAIL w0_rd_data got=%h exp=deadbeef", rdata0); end
        total++; if (rv0 !== 1'b1) begin bad++; $display("FAIL w0_rd_valid got=%b exp=1", rv0); end
        drv0(1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        total++; if (rv0 !== 1'b0) begin bad++; $display("FAIL w0_idle_valid got=%b exp=0", rv0); end
        total++; if (rdata0 !== 32'hDEADBEEF) begin bad++; $display("FAIL w0_idle_hold got=%h exp=deadbeef", rdata0); end
    endtask

    task automatic test_byte_lanes();
        drv0(1'b1, 4'b0101, 32'h10, 32'h11223344); tick();
        drv0(1'b1, 4'b0000, 32'h10, 32'h0); tick();
        total++; if (rdata0 !== 32'hDE22BE44) begin bad++; $display("FAIL lanes_0101 got=%h exp=de22be44", rdata0); end
        drv0(1'b0, 4'b1111, 32'h10, 32'hFFFFFFFF); tick();
        total++; if (rdata0 !== 32'hDE22BE44) begin bad++; $display("FAIL lanes_en0_hold got=%h exp=de22be44", rdata0); end
        drv0(1'b1, 4'b0000, 32'h10, 32'h0); tick();
        total++; if (rdata0 !== 32'hDE22BE44) begin bad++; $display("FAIL lanes_en0_write got=%h exp=de22be44", rdata0); end
        drv0(1'b1, 4'b0110, 32'h10, 32'hAABBCCDD); tick();
        drv0(1'b1, 4'b0000, 32'h10, 32'h0); tick();
        total++; if (rdata0 !== 32'hDEBBCC44) begin bad++; $display("FAIL lanes_0110 got=%h exp=debbcc44", rdata0); end
        m0[4] = 32'hDEBBCC44;
        drv0(1'b0, 4'h0, 32'h0, 32'h0); tick();
    endtask

    task automatic test_alias();
        drv0(1'b1, 4'hF, 32'h00001004, 32'h12345678); tick();
        m0[1] = 32'h12345678;
        drv0(1'b1, 4'h0, 32'h00000004, 32'h0); tick();
        total++; if (rdata0 !== 32'h12345678) begin bad++; $display("FAIL alias_4 got=%h exp=12345678", rdata0); end
        drv0(1'b1, 4'h0, 32'h00000007, 32'h0); tick();
        total++; if (rdata0 !== 32'h12345678) begin bad++; $display("FAIL alias_7 got=%h exp=12345678", rdata0); end
        drv0(1'b0, 4'h0, 32'h0, 32'h0); tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] old_v;
        old_v = m0[4];
        drv0(1'b1, 4'h0, 32'h10, 32'h0); tick();
        total++; if (rdata0 !== old_v || rv0 !== 1'b1) begin bad++; $display("FAIL b2b_rd1 got=%h/%b exp=%h/1", rdata0, rv0, old_v); end
        drv0(1'b1, 4'hF, 32'h10, 32'h0BADF00D); tick();
        m0[4] = 32'h0BADF00D;
        total++; if (rdata0 !== old_v || rv0 !== 1'b0) begin bad++; $display("FAIL b2b_wr got=%h/%b exp=%h/0", rdata0, rv0, old_v); end
        drv0(1'b1, 4'h0, 32'h10, 32'h0); tick();
        total++; if (rdata0 !== 32'h0BADF00D || rv0 !== 1'b1) begin bad++; $display("FAIL b2b_rd2 got=%h/%b exp=0badf00d/1", rdata0, rv0); end
        drv0(1'b0, 4'h0, 32'h0, 32'h0); tick();
        total++; if (rv0 !== 1'b0) begin bad++; $display("FAIL b2b_tail_valid got=%b exp=0", rv0); end
    endtask

    task automatic test_random0();
        int idxs[8];
        logic [31:0] exp_rd, a, d;
        logic e;
        logic [3:0] w;
        int id;
        for (int k = 0; k < 8; k++) begin
            idxs[k] = k * 37 + 3;
            d = $urandom();
            drv0(1'b1, 4'hF, 32'(idxs[k]) << 2, d); tick();
            m0[idxs[k]] = d;
        end
        drv0(1'b1, 4'h0, 32'(idxs[0]) << 2, 32'h0); tick();
        exp_rd = m0[idxs[0]];
        for (int c = 0; c < 300; c++) begin
            id = idxs[$urandom_range(0, 7)];
            a  = {$urandom_range(0, 1048575), 10'(id), 2'($urandom_range(0, 3))};
            e  = ($urandom_range(0, 3) != 0);
            w  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            d  = $urandom();
            drv0(e, w, a, d);
            #1;
            total++; if (st0 !== 1'b0) begin bad++; $display("FAIL rnd0_stall c=%0d got=%b exp=0", c, st0); end
            tick();
            if (e && w == 4'h0) exp_rd = m0[widx(a)];
            else if (e) m0[widx(a)] = merge(m0[widx(a)], d, w);
            total++;
            if (rdata0 !== exp_rd || rv0 !== (e && w == 4'h0)) begin
                bad++; $display("FAIL rnd0_rd c=%0d got=%h/%b exp=%h/%b", c, rdata0, rv0, exp_rd, e && w == 4'h0);
            end
        end
        drv0(1'b0, 4'h0, 32'h0, 32'h0); tick();
    endtask

    task automatic test_wait3();
        drv3(1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (st3 !== (k < 3)) begin bad++; $display("FAIL w3_wr_stall k=%0d got=%b", k, st3); end
            tick();
            total++; if (rv3 !== 1'b0) begin bad++; $display("FAIL w3_wr_valid k=%0d got=%b exp=0", k, rv3); end
        end
        m3[4] = 32'hDEADBEEF;
        drv3(1'b0, 4'h0, 32'h0, 32'h0); tick();
        drv3(1'b1, 4'h0, 32'h10, 32'h0);
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (st3 !== (k < 3)) begin bad++; $display("FAIL w3_rd_stall k=%0d got=%b", k, st3); end
            tick();
            total++; if (rv3 !== (k == 3)) begin bad++; $display("FAIL w3_rd_valid k=%0d got=%b", k, rv3); end
        end
        total++; if (rdata3 !== 32'hDEADBEEF) begin bad++; $display("FAIL w3_rd_data got=%h exp=deadbeef", rdata3); end
        drv3(1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        total++; if (st3 !== 1'b0) begin bad++; $display("FAIL w3_after_stall got=%b exp=0", st3); end
        tick();
        total++; if (rv3 !== 1'b0) begin bad++; $display("FAIL w3_no_reaccept got=%b exp=0", rv3); end
    endtask

    task automatic test_reset_midwait();
        drv3(1'b1, 4'hF, 32'h20, 32'h0BADBEEF);
        for (int k = 0; k < 4; k++) tick();
        m3[8] = 32'h0BADBEEF;
        drv3(1'b0, 4'h0, 32'h0, 32'h0); tick();
        drv3(1'b1, 4'hF, 32'h20, 32'hCAFEF00D);
        #1;
        total++; if (st3 !== 1'b1) begin bad++; $display("FAIL rmw_start_stall got=%b exp=1", st3); end
        tick();
        rst3 = 1'b1;
        #1;
        total++; if (st3 !== 1'b0) begin bad++; $display("FAIL rmw_stall got=%b exp=0", st3); end
        total++; if (rdata3 !== 32'd0) begin bad++; $display("FAIL rmw_rdata got=%h exp=0", rdata3); end
        tick();
        drv3(1'b0, 4'h0, 32'h0, 32'h0);
        rst3 = 1'b0;
        tick();
        drv3(1'b1, 4'h0, 32'h20, 32'h0);
        for (int k = 0; k < 4; k++) tick();
        total++; if (rdata3 !== 32'h0BADBEEF || rv3 !== 1'b1) begin bad++; $display("FAIL rmw_readback got=%h/%b exp=0badbeef/1", rdata3, rv3); end
        drv3(1'b0, 4'h0, 32'h0, 32'h0); tick();
    endtask

    task automatic test_random3();
        int idxs[4];
        logic [31:0] exp_rd, a, d;
        logic [3:0] w;
        for (int k = 0; k < 4; k++) idxs[k] = k * 101 + 17;
        for (int k = 0; k < 4; k++) begin
            d = $urandom();
            drv3(1'b1, 4'hF, 32'(idxs[k]) << 2, d);
            for (int j = 0; j < 4; j++) tick();
            m3[idxs[k]] = d;
        end
        exp_rd = m3[8];
        for (int r = 0; r < 25; r++) begin
            a = {$urandom_range(0, 1048575), 10'(idxs[$urandom_range(0, 3)]), 2'($urandom_range(0, 3))};
            w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            d = $urandom();
            drv3(1'b0, 4'h0, 32'h0, 32'h0); tick();
            drv3(1'b1, w, a, d);
            for (int k = 0; k < 4; k++) begin
                #1;
                total++; if (st3 !== (k < 3)) begin bad++; $display("FAIL rnd3_stall r=%0d k=%0d got=%b", r, k, st3); end
                tick();
                if (k == 3) begin
                    if (w == 4'h0) exp_rd = m3[widx(a)];
                    else m3[widx(a)] = merge(m3[widx(a)], d, w);
                end
            end
            total++;
            if (rdata3 !== exp_rd || rv3 !== (w == 4'h0)) begin
                bad++; $display("FAIL rnd3_rd r=%0d got=%h/%b exp=%h/%b", r, rdata3, rv3, exp_rd, w == 4'h0);
            end
        end
        drv3(1'b0, 4'h0, 32'h0, 32'h0); tick();
    endtask

    initial begin
        test_reset();
        test_w0_basic();
        test_byte_lanes();
        test_alias();
        test_back_to_back();
        test_random0();
        test_wait3();
        test_reset_midwait();
        test_random3();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
